// File: rtl/row_idct.sv
// row_idct: one-dimensional 8-point inverse DCT applied to one row of an
// 8x8 block per cycle.
//   x_n = (sum_k X_k * M[n][k] + 64) >>> 7, with 24-bit signed accumulation
//   and 7-bit integer cosine weights (M[n][0] = 128).
// Five register ranks: the accepted row is captured, then passes through
// products, half sums, full sums and the rounded output register. A row
// accepted on edge t is therefore presented on edge t+4.
// Every rank advances together whenever o_ready is high. o_ready is
// i_ready OR NOT o_valid, so bubbles drain even while the sink stalls.
// Build option: define ROW_IDCT_SAT_EN to clamp results to [-2048, 2047].
// Without it, the low 12 bits of the shifted sum are kept (two's-complement
// wrap).
module row_idct (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [11:0] i_data0,
  input  logic signed [11:0] i_data1,
  input  logic signed [11:0] i_data2,
  input  logic signed [11:0] i_data3,
  input  logic signed [11:0] i_data4,
  input  logic signed [11:0] i_data5,
  input  logic signed [11:0] i_data6,
  input  logic signed [11:0] i_data7,
  input  logic               i_ready,
  output logic               o_valid,
  output logic               o_last,
  output logic [2:0]         o_row,
  output logic signed [11:0] o_data0,
  output logic signed [11:0] o_data1,
  output logic signed [11:0] o_data2,
  output logic signed [11:0] o_data3,
  output logic signed [11:0] o_data4,
  output logic signed [11:0] o_data5,
  output logic signed [11:0] o_data6,
  output logic signed [11:0] o_data7
);

  // Weights for cos(m*pi/16), m = 0..8, scaled by 128 and rounded.
  function automatic logic signed [8:0] cos_tab(input int m);
    logic signed [8:0] c;
    case (m)
      0:       c = 9'sd128;
      1:       c = 9'sd126;
      2:       c = 9'sd118;
      3:       c = 9'sd106;
      4:       c = 9'sd91;
      5:       c = 9'sd71;
      6:       c = 9'sd49;
      7:       c = 9'sd25;
      default: c = 9'sd0;
    endcase
    return c;
  endfunction

  // M[n][k]: fold the angle (2n+1)k*pi/16 into the first quadrant.
  function automatic logic signed [8:0] coef(input int n, input int k);
    int m;
    m = ((2 * n + 1) * k) % 32;
    if (m <= 8)       return cos_tab(m);
    else if (m <= 16) return -cos_tab(16 - m);
    else if (m <= 24) return -cos_tab(m - 16);
    else              return cos_tab(32 - m);
  endfunction

  logic signed [11:0] din    [8];
  logic signed [11:0] s0_x   [8];
  logic signed [23:0] s1_p   [8][8];
  logic signed [23:0] s2_lo  [8];
  logic signed [23:0] s2_hi  [8];
  logic signed [23:0] s3_acc [8];
  logic signed [11:0] y_nxt  [8];
  logic signed [11:0] s4_y   [8];
  logic [3:0]         vld;
  logic               adv;

  assign din[0] = i_data0;
  assign din[1] = i_data1;
  assign din[2] = i_data2;
  assign din[3] = i_data3;
  assign din[4] = i_data4;
  assign din[5] = i_data5;
  assign din[6] = i_data6;
  assign din[7] = i_data7;

  assign o_ready = i_ready | ~o_valid;
  assign adv     = o_ready;
  assign o_last  = o_valid & (o_row == 3'd7);

  assign o_data0 = s4_y[0];
  assign o_data1 = s4_y[1];
  assign o_data2 = s4_y[2];
  assign o_data3 = s4_y[3];
  assign o_data4 = s4_y[4];
  assign o_data5 = s4_y[5];
  assign o_data6 = s4_y[6];
  assign o_data7 = s4_y[7];

  // Round to nearest (add half an LSB, then arithmetic shift), then clamp or wrap to 12 bits.
`ifdef ROW_IDCT_SAT_EN
  logic signed [23:0] sh [8];
`endif
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      y_nxt[n] = '0;
`ifdef ROW_IDCT_SAT_EN
      sh[n] = (s3_acc[n] + 24'sd64) >>> 7;
      if (sh[n] > 24'sd2047)
        y_nxt[n] = 12'sd2047;
      else if (sh[n] < -24'sd2048)
        y_nxt[n] = -12'sd2048;
      else
        y_nxt[n] = sh[n][11:0];
`else
      y_nxt[n] = 12'((s3_acc[n] + 24'sd64) >>> 7);
`endif
    end
  end

  // Control and output rank: valid shift register, row counter, and output samples.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld     <= '0;
      o_valid <= 1'b0;
      o_row   <= 3'd0;
      for (int n = 0; n < 8; n++) s4_y[n] <= '0;
    end else begin
      if (o_valid && i_ready) o_row <= o_row + 3'd1;
      if (adv) begin
        vld     <= {vld[2:0], i_valid};
        o_valid <= vld[3];
        for (int n = 0; n < 8; n++) s4_y[n] <= y_nxt[n];
      end
    end
  end

  // Datapath ranks (capture, products, half sums, full sums).
  // These need no reset because their valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      if (i_valid)
        for (int k = 0; k < 8; k++) s0_x[k] <= din[k];
      for (int n = 0; n < 8; n++) begin
        for (int k = 0; k < 8; k++)
          s1_p[n][k] <= 24'(s0_x[k]) * 24'(coef(n, k));
        s2_lo[n]  <= s1_p[n][0] + s1_p[n][1] + s1_p[n][2] + s1_p[n][3];
        s2_hi[n]  <= s1_p[n][4] + s1_p[n][5] + s1_p[n][6] + s1_p[n][7];
        s3_acc[n] <= s2_lo[n] + s2_hi[n];
      end
    end
  end

endmodule

// File: tb/tb_row_idct.sv
// tb_row_idct: directed test of row_idct covering reset, DC rounding,
// single-basis rows, overflow (saturating or wrapping, depending on
// ROW_IDCT_SAT_EN), backpressure, the row counter and asynchronous reset.
module tb_row_idct;

  typedef logic signed [11:0] row_t [8];

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic               i_ready;
  logic               o_ready;
  logic               o_valid;
  logic               o_last;
  logic [2:0]         o_row;
  logic signed [11:0] id [8];
  logic signed [11:0] od [8];

  int checks = 0;
  int errors = 0;
  int exp_row = 0;
  row_t x, e;

  row_idct dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data0 (id[0]), .i_data1 (id[1]), .i_data2 (id[2]), .i_data3 (id[3]),
    .i_data4 (id[4]), .i_data5 (id[5]), .i_data6 (id[6]), .i_data7 (id[7]),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_row   (o_row),
    .o_data0 (od[0]), .o_data1 (od[1]), .o_data2 (od[2]), .o_data3 (od[3]),
    .o_data4 (od[4]), .o_data5 (od[5]), .o_data6 (od[6]), .o_data7 (od[7])
  );

  always #5 i_clk = ~i_clk;

  // One row through an idle pipeline: silent for edges t..t+3, present after t+4.
  task automatic run_single(input row_t xr, input row_t er, input string nm);
    i_valid = 1'b1;
    id      = xr;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid at +%0d: got %b, expected 0", nm, c, o_valid);
      end
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: o_valid got %b, expected 1", nm, o_valid);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (od[n] !== er[n]) begin
        errors++;
        $display("FAIL %s data%0d: got %0d, expected %0d", nm, n, od[n], er[n]);
      end
    end
    checks++;
    if (o_row !== 3'(exp_row)) begin
      errors++;
      $display("FAIL %s row: got %0d, expected %0d", nm, o_row, exp_row);
    end
    checks++;
    if (o_last !== (exp_row == 7)) begin
      errors++;
      $display("FAIL %s last: got %b, expected %b", nm, o_last, (exp_row == 7));
    end
    @(posedge i_clk); #1;
    exp_row = (exp_row + 1) % 8;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s duplicate: o_valid got %b, expected 0", nm, o_valid);
    end
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b0;
    #2;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", o_ready); end
    checks++; if (o_row !== 3'd0) begin errors++; $display("FAIL rst_row: got %0d, expected 0", o_row); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b, expected 0", o_last); end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (od[n] !== 12'sd0) begin errors++; $display("FAIL rst_data%0d: got %0d, expected 0", n, od[n]); end
    end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b, expected 0", o_valid); end
    #3 i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, expected 1", o_ready); end
    exp_row = 0;
  endtask

  task automatic test_dc();
    x = '{default: 12'sd0}; x[0] = 12'sd100;  e = '{default: 12'sd100};
    run_single(x, e, "dc_pos");
    x = '{default: 12'sd0}; x[0] = -12'sd100; e = '{default: -12'sd100};
    run_single(x, e, "dc_neg");
    x = '{default: 12'sd0}; x[0] = 12'sd1;    e = '{default: 12'sd1};
    run_single(x, e, "dc_one");
    x = '{default: 12'sd0}; x[0] = -12'sd1;   e = '{default: -12'sd1};
    run_single(x, e, "dc_minus_one");
  endtask

  task automatic test_basis();
    x = '{default: 12'sd0}; x[1] = 12'sd128;
    e = '{12'sd126, 12'sd106, 12'sd71, 12'sd25, -12'sd25, -12'sd71, -12'sd106, -12'sd126};
    run_single(x, e, "basis_x1");
    x = '{default: 12'sd0}; x[2] = 12'sd128;
    e = '{12'sd118, 12'sd49, -12'sd49, -12'sd118, -12'sd118, -12'sd49, 12'sd49, 12'sd118};
    run_single(x, e, "basis_x2");
    x = '{default: 12'sd0}; x[4] = -12'sd128;
    e = '{-12'sd91, 12'sd91, 12'sd91, -12'sd91, -12'sd91, 12'sd91, 12'sd91, -12'sd91};
    run_single(x, e, "basis_x4_neg");
    x = '{default: 12'sd0}; x[7] = 12'sd5;
    e = '{12'sd1, -12'sd3, 12'sd4, -12'sd5, 12'sd5, -12'sd4, 12'sd3, -12'sd1};
    run_single(x, e, "basis_x7_round");
  endtask

  task automatic test_overflow();
    x = '{default: 12'sd0}; x[0] = 12'sd2047; x[1] = 12'sd2047;
`ifdef ROW_IDCT_SAT_EN
    e = '{12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, 12'sd1647, 12'sd912, 12'sd352, 12'sd32};
`else
    e = '{-12'sd34, -12'sd354, -12'sd914, -12'sd1649, 12'sd1647, 12'sd912, 12'sd352, 12'sd32};
`endif
    run_single(x, e, "overflow");
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    int  got = 0;
    int  stall = 0;
    logic acc;
    for (int c = 0; c < 40 && got < 6; c++) begin
      i_ready = (o_valid && stall < 3) ? 1'b0 : 1'b1;
      id = '{default: 12'sd0};
      if (sent < 6) begin
        i_valid = 1'b1;
        id[0]   = 12'(10 * (sent + 1));
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (!i_ready) begin
        stall++;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b, expected 0", o_ready); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid: got %b, expected 1", o_valid); end
        checks++; if (od[0] !== 12'sd10) begin errors++; $display("FAIL bp_stall_data0: got %0d, expected 10", od[0]); end
        checks++; if (od[7] !== 12'sd10) begin errors++; $display("FAIL bp_stall_data7: got %0d, expected 10", od[7]); end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (od[0] !== 12'(10 * (got + 1)) || od[5] !== 12'(10 * (got + 1))) begin
          errors++;
          $display("FAIL bp_order row %0d: got %0d/%0d, expected %0d", got, od[0], od[5], 10 * (got + 1));
        end
        checks++;
        if (o_row !== 3'(exp_row)) begin
          errors++;
          $display("FAIL bp_row: got %0d, expected %0d", o_row, exp_row);
        end
        exp_row = (exp_row + 1) % 8;
        got++;
      end
      acc = i_valid & o_ready;
      @(posedge i_clk); #1;
      if (acc) sent++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_count: got %0d rows, expected 6", got); end
    checks++; if (stall !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d, expected 3", stall); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_row: o_valid got %b, expected 0", o_valid); end
  endtask

  task automatic test_row_counter();
    int idx = 0;
    int first = -1;
    int lastc = 0;
    i_rst = 1'b0;
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;
    exp_row = 0;
    i_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      id = '{default: 12'sd0};
      if (c < 16) begin
        i_valid = 1'b1;
        id[0]   = 12'(c + 1);
      end else begin
        i_valid = 1'b0;
      end
      @(posedge i_clk); #1;
      if (o_valid) begin
        checks++;
        if (o_row !== 3'(idx % 8)) begin errors++; $display("FAIL rc_row %0d: got %0d, expected %0d", idx, o_row, idx % 8); end
        checks++;
        if (o_last !== ((idx % 8) == 7)) begin errors++; $display("FAIL rc_last %0d: got %b, expected %b", idx, o_last, ((idx % 8) == 7)); end
        checks++;
        if (od[0] !== 12'(idx + 1)) begin errors++; $display("FAIL rc_data %0d: got %0d, expected %0d", idx, od[0], idx + 1); end
        if (first < 0) first = c;
        lastc = c;
        idx++;
      end
    end
    i_valid = 1'b0;
    checks++; if (idx !== 16) begin errors++; $display("FAIL rc_count: got %0d, expected 16", idx); end
    checks++; if (first !== 4) begin errors++; $display("FAIL rc_first_cycle: got %0d, expected 4", first); end
    checks++; if (lastc - first !== 15) begin errors++; $display("FAIL rc_throughput: span got %0d, expected 15", lastc - first); end
    exp_row = 0;
  endtask

  task automatic test_async_reset();
    x = '{default: 12'sd0}; x[0] = 12'sd50; e = '{default: 12'sd50};
    run_single(x, e, "pre_reset");
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      id = '{default: 12'sd0};
      i_valid = 1'b1;
      id[0] = 12'(200 + c);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b1 || od[0] !== 12'sd200) begin errors++; $display("FAIL ar_pre_out: valid %b data %0d, expected 1/200", o_valid, od[0]); end
    checks++; if (o_row !== 3'd1) begin errors++; $display("FAIL ar_pre_row: got %0d, expected 1", o_row); end
    #2 i_rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b, expected 0", o_valid); end
    checks++; if (od[0] !== 12'sd0 || od[7] !== 12'sd0) begin errors++; $display("FAIL ar_data: got %0d/%0d, expected 0", od[0], od[7]); end
    checks++; if (o_row !== 3'd0) begin errors++; $display("FAIL ar_row: got %0d, expected 0", o_row); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b, expected 1", o_ready); end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ar_hold_valid: got %b, expected 0", o_valid); end
    #3 i_rst = 1'b1;
    @(posedge i_clk); #1;
    exp_row = 0;
    x = '{default: 12'sd0}; x[0] = 12'sd77; e = '{default: 12'sd77};
    run_single(x, e, "post_reset");
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    id      = '{default: 12'sd0};
    test_reset();
    test_dc();
    test_basis();
    test_overflow();
    test_backpressure();
    test_row_counter();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
